// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DMA  = 1'b1;

  typedef struct packed {
    logic vld;
    logic id;
  } rsp_tag_t;

  function automatic logic [1:0] onehot_id(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant; while locked only the lock owner can be granted.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_winner,
  input  logic       lock_owner,
  input  logic       locked,
  output logic [1:0] grant
);

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant = 2'b00;
    if (locked) begin
      if (valid[lock_owner]) begin
        grant = onehot_id(lock_owner);
      end
    end else if (valid == 2'b11) begin
      grant = onehot_id(~last_winner);
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between the core (0) and a DMA master (1).
// Optional MEM_ARB_PERF_EN adds per-requester wait-cycle counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_we,
  input  logic [1:0]      req_lock,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      req_ready,
  output logic [1:0]      rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            mem_rd_en,
  output logic            mem_wr_en,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wr_dat,
  input  logic [DW-1:0]   mem_rd_dat
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_wait0,
  output logic [31:0]     perf_wait1
`endif
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  arb_state_e state;
  logic       last_winner;
  logic [3:0] burst_cnt;
  rsp_tag_t   rsp_pipe [RD_LAT];
  rsp_tag_t   rsp_tail;
  logic [1:0] grant;
  logic       accept;
  logic       winner;

  mem_arb_rr u_rr (
    .valid       (req_valid),
    .last_winner (last_winner),
    .lock_owner  (last_winner),
    .locked      (state == LOCKED),
    .grant       (grant)
  );

  // Grants are suppressed while reset is held so the port is fully quiet.
  assign req_ready = reset ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign winner    = req_ready[REQ_DMA];

  always_comb begin
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wr_dat = '0;
    if (accept) begin
      mem_rd_en = ~req_we[winner];
      mem_wr_en = req_we[winner];
      if (winner == REQ_CORE) begin
        mem_addr   = req_addr[0 +: AW];
        mem_wr_dat = req_wdata[0 +: DW];
      end else begin
        mem_addr   = req_addr[AW +: AW];
        mem_wr_dat = req_wdata[DW +: DW];
      end
    end
  end

  // In LOCKED the owner is last_winner; an idle owner cycle releases the lock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB;
      last_winner <= REQ_DMA;
      burst_cnt   <= '0;
    end else begin
      case (state)
        ARB: begin
          if (accept) begin
            last_winner <= winner;
            if (req_lock[winner] && (MAX_BURST > 1)) begin
              state     <= LOCKED;
              burst_cnt <= 4'd1;
            end
          end
        end
        LOCKED: begin
          if (!req_valid[last_winner]) begin
            state     <= ARB;
            burst_cnt <= '0;
          end else if (accept) begin
            if (!req_lock[last_winner] || (burst_cnt + 4'd1 == MAX_B)) begin
              state     <= ARB;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + 4'd1;
            end
          end
        end
        default: begin
          state     <= ARB;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rsp_pipe[i] <= '0;
      end
    end else begin
      rsp_pipe[0] <= '{vld: mem_rd_en, id: winner};
      for (int i = 1; i < RD_LAT; i++) begin
        rsp_pipe[i] <= rsp_pipe[i-1];
      end
    end
  end

  assign rsp_tail  = rsp_pipe[RD_LAT-1];
  assign rsp_valid = rsp_tail.vld ? onehot_id(rsp_tail.id) : 2'b00;
  assign rsp_rdata = rsp_tail.vld ? mem_rd_dat : '0;

`ifdef MEM_ARB_PERF_EN
  // Saturating counts of cycles each requester spent waiting for a grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_wait0 <= '0;
      perf_wait1 <= '0;
    end else begin
      if (req_valid[0] && !req_ready[0] && (perf_wait0 != 32'hFFFF_FFFF)) begin
        perf_wait0 <= perf_wait0 + 32'd1;
      end
      if (req_valid[1] && !req_ready[1] && (perf_wait1 != 32'hFFFF_FFFF)) begin
        perf_wait1 <= perf_wait1 + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory.
// Inputs change 1ns after the rising edge; outputs are checked 4ns after it.
module tb_mem_arbiter;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int RD_LAT    = 1;
  localparam int MAX_BURST = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_we = '0;
  logic [1:0]      req_lock = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_rd_en;
  logic            mem_wr_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wr_dat;
  logic [DW-1:0]   mem_rd_dat;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]     perf_wait0;
  logic [31:0]     perf_wait1;
`endif

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_lock   (req_lock),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wr_dat (mem_wr_dat),
    .mem_rd_dat (mem_rd_dat)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_wait0 (perf_wait0),
    .perf_wait1 (perf_wait1)
`endif
  );

  always #5 clk = ~clk;

  // Unwritten locations read back as 0xA000_0000 | addr.
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] rd_dly [RD_LAT];

  always @(posedge clk) begin
    if (mem_rd_en) begin
      rd_dly[0] <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : (32'hA000_0000 | mem_addr);
    end
    for (int i = 1; i < RD_LAT; i++) begin
      rd_dly[i] <= rd_dly[i-1];
    end
    if (mem_wr_en) begin
      mem_model[mem_addr] = mem_wr_dat;
    end
  end

  assign mem_rd_dat = rd_dly[RD_LAT-1];

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic test_reset;
    drive(2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0);
    #3;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_ready got=%b exp=00", req_ready); end
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    vectors++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_mem_en got=%b exp=00", {mem_rd_en, mem_wr_en}); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    vectors++; if (mem_wr_dat !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_wr_dat got=%h exp=0", mem_wr_dat); end
    next_cycle;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    #3;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL idle_ready got=%b exp=00", req_ready); end
  endtask

  task automatic test_both_read;
    next_cycle;
    drive(2'b11, 2'b00, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0);
    #3;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL tie_ready0 got=%b exp=01", req_ready); end
    vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("[TB] FAIL tie_addr0 got=%h exp=10", mem_addr); end
    vectors++; if (mem_rd_en !== 1'b1) begin miscompares++; $display("[TB] FAIL tie_rd_en0 got=%b exp=1", mem_rd_en); end
    next_cycle;
    drive(2'b10, 2'b00, 2'b00, 32'h0, 32'h20, 32'h0, 32'h0);
    #3;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("[TB] FAIL tie_ready1 got=%b exp=10", req_ready); end
    vectors++; if (mem_addr !== 32'h20) begin miscompares++; $display("[TB] FAIL tie_addr1 got=%h exp=20", mem_addr); end
    vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("[TB] FAIL tie_rsp0 got=%b exp=01", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'hA000_0010) begin miscompares++; $display("[TB] FAIL tie_rdata0 got=%h exp=a0000010", rsp_rdata); end
    next_cycle;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #3;
    vectors++; if (rsp_valid !== 2'b10) begin miscompares++; $display("[TB] FAIL tie_rsp1 got=%b exp=10", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'hA000_0020) begin miscompares++; $display("[TB] FAIL tie_rdata1 got=%h exp=a0000020", rsp_rdata); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL tie_ready_idle got=%b exp=00", req_ready); end
    next_cycle;
    #3;
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL tie_rsp_idle got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_write_read;
    next_cycle;
    drive(2'b01, 2'b01, 2'b00, 32'h40, 32'h0, 32'hDEAD_BEEF, 32'h0);
    #3;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL wr_ready got=%b exp=01", req_ready); end
    vectors++; if ({mem_wr_en, mem_rd_en} !== 2'b10) begin miscompares++; $display("[TB] FAIL wr_en got=%b exp=10", {mem_wr_en, mem_rd_en}); end
    vectors++; if (mem_wr_dat !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL wr_dat got=%h exp=deadbeef", mem_wr_dat); end
    next_cycle;
    drive(2'b01, 2'b00, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0);
    #3;
    vectors++; if ({mem_wr_en, mem_rd_en} !== 2'b01) begin miscompares++; $display("[TB] FAIL rd_en got=%b exp=01", {mem_wr_en, mem_rd_en}); end
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL wr_no_rsp got=%b exp=00", rsp_valid); end
    next_cycle;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #3;
    vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("[TB] FAIL rd_rsp got=%b exp=01", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd_rdata got=%h exp=deadbeef", rsp_rdata); end
    vectors++; if (mem_wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_one_cycle got=%b exp=0", mem_wr_en); end
    next_cycle;
    #3;
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL rd_rsp_idle got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_burst_lock;
    logic [1:0] exp_tbl [7];
    logic [1:0] v;
    int beats;
    bit core_done;
    exp_tbl = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
    beats = 0;
    core_done = 1'b0;
    for (int c = 0; c < 7; c++) begin
      next_cycle;
      v[1] = (beats < 6);
      v[0] = (c >= 1) && !core_done;
      drive(v, 2'b00, 2'b10, 32'h80, 32'h100 + 32'(4 * beats), 32'h0, 32'h0);
      #3;
      vectors++; if (req_ready !== exp_tbl[c]) begin miscompares++; $display("[TB] FAIL burst_ready[%0d] got=%b exp=%b", c, req_ready, exp_tbl[c]); end
      if (req_ready[1]) beats++;
      if (req_ready[0]) core_done = 1'b1;
    end
    next_cycle;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #3;
    vectors++; if (beats != 6) begin miscompares++; $display("[TB] FAIL burst_dma_beats got=%0d exp=6", beats); end
    next_cycle;
  endtask

  task automatic test_lock_drop;
    next_cycle;
    drive(2'b10, 2'b00, 2'b10, 32'h0, 32'h200, 32'h0, 32'h0);
    #3;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("[TB] FAIL drop_owner_grant got=%b exp=10", req_ready); end
    next_cycle;
    drive(2'b01, 2'b00, 2'b10, 32'h84, 32'h204, 32'h0, 32'h0);
    #3;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL drop_other_waits got=%b exp=00", req_ready); end
    next_cycle;
    drive(2'b11, 2'b00, 2'b10, 32'h84, 32'h204, 32'h0, 32'h0);
    #3;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL drop_other_granted got=%b exp=01", req_ready); end
    vectors++; if (mem_addr !== 32'h84) begin miscompares++; $display("[TB] FAIL drop_addr got=%h exp=84", mem_addr); end
    next_cycle;
    drive(2'b10, 2'b00, 2'b00, 32'h0, 32'h204, 32'h0, 32'h0);
    #3;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("[TB] FAIL drop_dma_resume got=%b exp=10", req_ready); end
    next_cycle;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle;
  endtask

  task automatic test_async_reset;
    next_cycle;
    drive(2'b10, 2'b00, 2'b10, 32'h0, 32'h30, 32'h0, 32'h0);
    #3;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("[TB] FAIL ar_grant got=%b exp=10", req_ready); end
    next_cycle;
    drive(2'b11, 2'b00, 2'b10, 32'h38, 32'h34, 32'h0, 32'h0);
    #1;
    vectors++; if (rsp_valid !== 2'b10) begin miscompares++; $display("[TB] FAIL ar_rsp_before got=%b exp=10", rsp_valid); end
    reset = 1'b0;
    #1;
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL ar_rsp_dropped got=%b exp=00", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL ar_rdata got=%h exp=0", rsp_rdata); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("[TB] FAIL ar_ready got=%b exp=00", req_ready); end
    vectors++; if ({mem_rd_en, mem_wr_en, |mem_addr} !== 3'b000) begin miscompares++; $display("[TB] FAIL ar_mem got=%b exp=000", {mem_rd_en, mem_wr_en, |mem_addr}); end
    next_cycle;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3;
      vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL ar_no_rsp[%0d] got=%b exp=00", c, rsp_valid); end
      next_cycle;
    end
    drive(2'b11, 2'b00, 2'b00, 32'h50, 32'h60, 32'h0, 32'h0);
    #3;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("[TB] FAIL ar_lock_released got=%b exp=01", req_ready); end
    next_cycle;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    next_cycle;
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf;
    reset = 1'b0;
    #3;
    vectors++; if ({perf_wait0, perf_wait1} !== 64'h0) begin miscompares++; $display("[TB] FAIL perf_reset got=%h/%h exp=0/0", perf_wait0, perf_wait1); end
    next_cycle;
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      next_cycle;
      drive(2'b11, 2'b00, 2'b00, 32'h70, 32'h74, 32'h0, 32'h0);
    end
    next_cycle;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #3;
    vectors++; if (perf_wait0 !== 32'd5) begin miscompares++; $display("[TB] FAIL perf_wait0 got=%0d exp=5", perf_wait0); end
    vectors++; if (perf_wait1 !== 32'd5) begin miscompares++; $display("[TB] FAIL perf_wait1 got=%0d exp=5", perf_wait1); end
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset;
    test_both_read;
    test_write_read;
    test_burst_lock;
    test_lock_drop;
    test_async_reset;
`ifdef MEM_ARB_PERF_EN
    test_perf;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory port between two requesters: requester 0 is the core load/store path (MemRead/MemWrite/m_addr); requester 1 is a DMA/program-loader master.
- Sits between riscv_core and the data memory inside the top-level wrapper.
- Arbitrates round-robin with an optional short burst lock.
- Routes read data back to the issuing requester after the memory's fixed read latency.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles (mem_rd_dat is valid RD_LAT cycles after mem_rd_en); legal range 1..4.
- MAX_BURST, 4, maximum consecutive accepted beats per locked owner; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_we  in  2  per-requester write (1) / read (0).
- req_lock  in  2  owner requests to keep the grant for the next beat.
- req_addr  in  2*AW  per-requester address (requester i at bits [i*AW +: AW]).
- req_wdata  in  2*DW  per-requester write data.
- req_ready  out  2  grant; a request is accepted when valid && ready.
- rsp_valid  out  2  read response valid.
- rsp_rdata  out  DW  read data (shared bus, qualified by rsp_valid).
- mem_rd_en  out  1  memory read enable.
- mem_wr_en  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wr_dat  out  DW  memory write data.
- mem_rd_dat  in  DW  memory read data.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wr_dat=0. Internal resets: state=ARB, last_winner=1 (so the core wins the first tie), burst_cnt=0, response pipeline cleared.
- Handshake rules:
  - req_ready is combinational from state, last_winner and req_valid. It is never dependent on req_ready of the other requester's acceptance in a later cycle.
  - A requester holds valid/we/addr/wdata/lock stable until accepted.
  - At most one req_ready bit is high per cycle. Both are 0 when no valid is high.
- Memory port:
  - Driven combinationally from the granted requester in the acceptance cycle.
  - mem_rd_en = accept && !we; mem_wr_en = accept && we.
  - When nothing is accepted: enables 0, addr and wdata 0.
- State ARB:
  - One valid: grant it.
  - Both valid: grant the requester that is not last_winner.
  - On accept: last_winner <= winner.
  - If the winner's req_lock=1 and MAX_BURST>1: go to LOCKED with burst_cnt=1. Otherwise stay in ARB.
- State LOCKED (owner = last_winner):
  - Only the owner may be granted; the other requester waits even if the owner is idle.
  - On owner accept: burst_cnt++.
  - Return to ARB (burst_cnt<=0) when any of these holds:
    - the owner drops req_lock on an accepted beat;
    - burst_cnt reaches MAX_BURST on an accepted beat;
    - the owner has req_valid=0 for a cycle.
- Read response:
  - An RD_LAT-deep shift pipeline carries {valid, owner id} for each accepted read.
  - At the pipeline tail: rsp_valid[id]=1 and rsp_rdata=mem_rd_dat, combinationally in that cycle.
  - Writes produce no response.
  - Back-to-back reads, including alternating requesters, return in issue order, one per cycle.
- Boundary conditions:
  - A simultaneous request and response is legal.
  - Reset asserted mid-operation drops in-flight responses and releases any lock immediately.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_wait0 and perf_wait1 (32 bits each).
  - Each counts cycles with req_valid[i] && !req_ready[i].
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_e {ARB, LOCKED};
  - constants REQ_CORE=0, REQ_DMA=1;
  - a rsp_tag_t struct {logic vld; logic id;}.
- Sub-module mem_arb_rr (2-way round-robin grant logic: inputs valid, last_winner, lock_owner, locked; output one-hot grant) is natural.
- The FSM, burst counter and response pipeline stay in mem_arbiter.

Test Plan:
- Release reset; both read addr 0x10/0x20 in the same cycle -> core granted first, mem_addr=0x10; DMA granted next cycle, mem_addr=0x20; rsp_valid=01 then 10, each RD_LAT cycles after its accept.
- Core alone writes 0xDEADBEEF to 0x40, then reads 0x40 -> mem_wr_en=1 for one cycle; read returns rsp_valid[0] with rsp_rdata=0xDEADBEEF; rsp_valid[1] never asserted.
- DMA holds req_lock=1 with 6 reads while the core is valid, MAX_BURST=4 -> DMA gets 4 consecutive grants, core gets the 5th cycle, DMA resumes after.
- Lock owner drops valid for a cycle while the other requester is valid -> state returns to ARB and the other requester is granted the next cycle.
- Reset asserted asynchronously one cycle after a read is accepted -> all outputs go to 0 immediately; no rsp_valid after reset is released.
- With MEM_ARB_PERF_EN, both valid continuously for 10 cycles, no lock -> perf_wait0 and perf_wait1 each = 5.
